// File: rtl/pipeline_dest_tracker_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the EX-stage destination tracker:
//   REG_ADDR_W   - register-specifier width
//   REG_ZERO     - the hard-wired zero register
//   hz_state_e   - load-use hazard FSM states (RUN, STALL)
//   dest_info_t  - destination record carried through EX/MEM and MEM/WB
//   load_use_hazard() - the hazard term evaluated against the decode stage
// ---------------------------------------------------------------------------
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } dest_info_t;

  // A load in EX whose result is needed by the instruction in decode.
  // Register 0 never creates a dependency, and a squashed decode
  // instruction has nothing to wait for.
  function automatic logic load_use_hazard(
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  ex_regwrite,
    input logic                  ex_memread,
    input logic [REG_ADDR_W-1:0] id_rs,
    input logic [REG_ADDR_W-1:0] id_rt,
    input logic                  id_uses_rt,
    input logic                  flush
  );
    logic src_match;
    src_match = (ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt));
    return ex_memread & ex_regwrite & (ex_rd != REG_ZERO) & src_match & ~flush;
  endfunction

endpackage

// File: rtl/pipeline_dest_tracker_if.sv
// ---------------------------------------------------------------------------
// pipeline_dest_tracker_if
// Bundles the decode/EX inputs and the forwarding/stall outputs of the
// destination tracker.
//   master : the core side; drives decode and ID/EX fields, reads results
//   slave  : the tracker; reads decode and ID/EX fields, drives results
// Parameters must match the tracker instance it is connected to.
// ---------------------------------------------------------------------------
interface pipeline_dest_tracker_if #(
  parameter int REG_ADDR_W  = pipeline_pkg::REG_ADDR_W,
  parameter int STALL_CNT_W = 16
) ();

  // decode / EX inputs
  logic [REG_ADDR_W-1:0]  IF_ID_Register_Rs;
  logic [REG_ADDR_W-1:0]  IF_ID_Register_Rt;
  logic                   IF_ID_Uses_Rt;
  logic [REG_ADDR_W-1:0]  ID_EX_Register_Rd;
  logic                   ID_EX_RegWrite;
  logic                   ID_EX_MemRead;
  logic                   Flush;

  // forwarding destinations
  logic [REG_ADDR_W-1:0]  EX_MEM_Register_Rd;
  logic                   EX_MEM_RegWrite;
  logic [REG_ADDR_W-1:0]  MEM_WB_Register_Rd;
  logic                   MEM_WB_RegWrite;

  // stall control and status
  logic                   PC_Write;
  logic                   IF_ID_Write;
  logic                   ID_EX_Bubble;
  logic                   Protocol_Error;
  logic [STALL_CNT_W-1:0] Stall_Count;

  modport master (
    output IF_ID_Register_Rs, IF_ID_Register_Rt, IF_ID_Uses_Rt,
           ID_EX_Register_Rd, ID_EX_RegWrite, ID_EX_MemRead, Flush,
    input  EX_MEM_Register_Rd, EX_MEM_RegWrite,
           MEM_WB_Register_Rd, MEM_WB_RegWrite,
           PC_Write, IF_ID_Write, ID_EX_Bubble, Protocol_Error, Stall_Count
  );

  modport slave (
    input  IF_ID_Register_Rs, IF_ID_Register_Rt, IF_ID_Uses_Rt,
           ID_EX_Register_Rd, ID_EX_RegWrite, ID_EX_MemRead, Flush,
    output EX_MEM_Register_Rd, EX_MEM_RegWrite,
           MEM_WB_Register_Rd, MEM_WB_RegWrite,
           PC_Write, IF_ID_Write, ID_EX_Bubble, Protocol_Error, Stall_Count
  );

endinterface

// File: rtl/pipeline_dest_tracker_stage.sv
// ---------------------------------------------------------------------------
// pipe_dest_stage
// One pipeline register holding a dest_info_t record. Loads every cycle;
// a synchronous active-low reset clears it to Rd=0, RegWrite=0, MemRead=0.
//   clk   : core clock
//   rst_n : synchronous active-low clear
//   d     : record entering the stage
//   q     : record held by the stage
// ---------------------------------------------------------------------------
module pipe_dest_stage (
  input  logic                    clk,
  input  logic                    rst_n,
  input  pipeline_pkg::dest_info_t d,
  output pipeline_pkg::dest_info_t q
);
  import pipeline_pkg::*;

  dest_info_t info_q;
  dest_info_t info_d;

  always_comb begin
    info_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      info_q <= '0;
    end else begin
      info_q <= info_d;
    end
  end

  assign q = info_q;

endmodule

// File: rtl/pipeline_dest_tracker.sv
// ---------------------------------------------------------------------------
// pipeline_dest_tracker
// Carries the destination, write-enable and load flag of each instruction
// leaving EX through EX/MEM and MEM/WB for the forwarding comparators, and
// stalls decode for one cycle when a load result is needed immediately.
//   clk   : core clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave view of pipeline_dest_tracker_if
//             in : IF_ID_Register_Rs/Rt, IF_ID_Uses_Rt, ID_EX_Register_Rd,
//                  ID_EX_RegWrite, ID_EX_MemRead, Flush
//             out: EX_MEM_Register_Rd/RegWrite, MEM_WB_Register_Rd/RegWrite,
//                  PC_Write, IF_ID_Write, ID_EX_Bubble (combinational),
//                  Protocol_Error (sticky), Stall_Count (saturating)
// ---------------------------------------------------------------------------
module pipeline_dest_tracker #(
  parameter int REG_ADDR_W  = pipeline_pkg::REG_ADDR_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipeline_dest_tracker_if.slave  bus
);
  import pipeline_pkg::*;

  hz_state_e              state_q, state_d;
  logic                   err_q, err_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   hz;
  logic                   stall;

  dest_info_t             id_ex_info;
  dest_info_t             ex_mem_q;
  dest_info_t             mem_wb_q;
  logic                   unused_mem_wb_memread;

  assign hz = load_use_hazard(bus.ID_EX_Register_Rd, bus.ID_EX_RegWrite,
                              bus.ID_EX_MemRead, bus.IF_ID_Register_Rs,
                              bus.IF_ID_Register_Rt, bus.IF_ID_Uses_Rt,
                              bus.Flush);

  // Stall lasts exactly one cycle: the bubble inserted by that stall must
  // clear the hazard, so a hazard still present in STALL means the
  // surrounding pipeline failed to honour ID_EX_Bubble.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;

    case (state_q)
      RUN: begin
        if (hz) begin
          stall   = 1'b1;
          state_d = STALL;
        end
      end
      STALL: begin
        state_d = RUN;
        if (hz) begin
          err_d = 1'b1;
        end
      end
    endcase

    // Stall controls are released while reset is held so the front end
    // keeps running during reset.
    if (!rst_n) begin
      stall = 1'b0;
    end

    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // The load keeps advancing during a stall; only PC and IF/ID hold.
  assign id_ex_info = '{rd:       bus.ID_EX_Register_Rd,
                        regwrite: bus.ID_EX_RegWrite,
                        memread:  bus.ID_EX_MemRead};

  pipe_dest_stage u_ex_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (id_ex_info),
    .q     (ex_mem_q)
  );

  pipe_dest_stage u_mem_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ex_mem_q),
    .q     (mem_wb_q)
  );

  // The load flag has no consumer once the instruction reaches WB.
  assign unused_mem_wb_memread = mem_wb_q.memread;

  assign bus.EX_MEM_Register_Rd = ex_mem_q.rd;
  assign bus.EX_MEM_RegWrite    = ex_mem_q.regwrite;
  assign bus.MEM_WB_Register_Rd = mem_wb_q.rd;
  assign bus.MEM_WB_RegWrite    = mem_wb_q.regwrite;

  assign bus.PC_Write       = ~stall;
  assign bus.IF_ID_Write    = ~stall;
  assign bus.ID_EX_Bubble   = stall;
  assign bus.Protocol_Error = err_q;
  assign bus.Stall_Count    = cnt_q;

endmodule

// File: tb/tb_pipeline_dest_tracker.sv
// ---------------------------------------------------------------------------
// tb_pipeline_dest_tracker
// Directed scenarios plus randomized traffic for pipeline_dest_tracker,
// checked against a behavioural model: a two-deep history of ID/EX records,
// a "previous cycle stalled" flag, a sticky error bit and a saturating count.
// A narrow counter width keeps the saturation scenario short.
// ---------------------------------------------------------------------------
module tb_pipeline_dest_tracker;

  localparam int AW      = 5;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int OW      = 2 * (AW + 1) + 4 + CW;
  localparam logic [OW-1:0] RESET_OUT =
    {AW'(0), 1'b0, AW'(0), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CW'(0)};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_dest_tracker_if #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) bus ();

  pipeline_dest_tracker #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [AW-1:0] em_rd, wb_rd;
  bit            em_rw, wb_rw;
  bit            prev_stall;
  bit            exp_err;
  int            exp_cnt;

  function automatic bit exp_hz();
    if (bus.Flush) return 1'b0;
    if (!(bus.ID_EX_MemRead && bus.ID_EX_RegWrite)) return 1'b0;
    if (bus.ID_EX_Register_Rd == 0) return 1'b0;
    if (bus.ID_EX_Register_Rd == bus.IF_ID_Register_Rs) return 1'b1;
    return bus.IF_ID_Uses_Rt && (bus.ID_EX_Register_Rd == bus.IF_ID_Register_Rt);
  endfunction

  // A hazard stalls unless the previous cycle already stalled.
  function automatic bit exp_stall();
    return rst_n && exp_hz() && !prev_stall;
  endfunction

  function automatic logic [OW-1:0] model_out();
    bit s;
    s = exp_stall();
    return {em_rd, em_rw, wb_rd, wb_rw, !s, !s, s, exp_err, CW'(exp_cnt)};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.EX_MEM_Register_Rd, bus.EX_MEM_RegWrite,
            bus.MEM_WB_Register_Rd, bus.MEM_WB_RegWrite,
            bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble,
            bus.Protocol_Error, bus.Stall_Count};
  endfunction

  task automatic model_step();
    bit s, h;
    h = exp_hz();
    s = exp_stall();
    if (!rst_n) begin
      em_rd = '0; em_rw = 1'b0; wb_rd = '0; wb_rw = 1'b0;
      prev_stall = 1'b0; exp_err = 1'b0; exp_cnt = 0;
    end else begin
      wb_rd = em_rd; wb_rw = em_rw;
      em_rd = bus.ID_EX_Register_Rd; em_rw = bus.ID_EX_RegWrite;
      if (s && exp_cnt < CNT_MAX) exp_cnt++;
      if (prev_stall && h) exp_err = 1'b1;
      prev_stall = s;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input bit uses_rt, input logic [AW-1:0] rd,
                       input bit rw, input bit mr, input bit fl);
    bus.IF_ID_Register_Rs = rs;
    bus.IF_ID_Register_Rt = rt;
    bus.IF_ID_Uses_Rt     = uses_rt;
    bus.ID_EX_Register_Rd = rd;
    bus.ID_EX_RegWrite    = rw;
    bus.ID_EX_MemRead     = mr;
    bus.Flush             = fl;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(5, 0, 0, 5, 1, 1, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b110) begin
      errors++;
      $display("FAIL reset_stall_forced got=%b exp=110",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_out() !== RESET_OUT) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_out(), RESET_OUT);
    end
    rst_n = 1'b1;
    #1;
    $display("test_reset done");
  endtask

  task automatic test_forward_add();
    drive(0, 0, 0, 3, 1, 0, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b110) begin
      errors++;
      $display("FAIL add_nostall got=%b exp=110",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.EX_MEM_Register_Rd, bus.EX_MEM_RegWrite} !== {5'd3, 1'b1}) begin
      errors++;
      $display("FAIL add_ex_mem got rd=%0d rw=%b exp rd=3 rw=1",
               bus.EX_MEM_Register_Rd, bus.EX_MEM_RegWrite);
    end
    tick();
    checks++;
    if ({bus.MEM_WB_Register_Rd, bus.MEM_WB_RegWrite} !== {5'd3, 1'b1}) begin
      errors++;
      $display("FAIL add_mem_wb got rd=%0d rw=%b exp rd=3 rw=1",
               bus.MEM_WB_Register_Rd, bus.MEM_WB_RegWrite);
    end
    checks++;
    if (dut_out() !== model_out()) begin
      errors++;
      $display("FAIL add_model got=%h exp=%h", dut_out(), model_out());
    end
    tick();
    $display("test_forward_add done");
  endtask

  task automatic test_load_use_rs();
    drive(5, 0, 0, 5, 1, 1, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b001) begin
      errors++;
      $display("FAIL lu_rs_stall got=%b exp=001",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    tick();
    drive(5, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b110) begin
      errors++;
      $display("FAIL lu_rs_release got=%b exp=110",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    checks++;
    if (bus.Stall_Count !== CW'(1)) begin
      errors++;
      $display("FAIL lu_rs_count got=%0d exp=1", bus.Stall_Count);
    end
    tick();
    $display("test_load_use_rs done");
  endtask

  task automatic test_rt_uses();
    drive(1, 5, 0, 5, 1, 1, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b110) begin
      errors++;
      $display("FAIL rt_unused got=%b exp=110",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    tick();
    drive(1, 5, 1, 5, 1, 1, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b001) begin
      errors++;
      $display("FAIL rt_used got=%b exp=001",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_out() !== model_out()) begin
      errors++;
      $display("FAIL rt_model got=%h exp=%h", dut_out(), model_out());
    end
    tick();
    $display("test_rt_uses done");
  endtask

  task automatic test_zero_and_flush();
    drive(0, 0, 1, 0, 1, 1, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b110) begin
      errors++;
      $display("FAIL zero_reg got=%b exp=110",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    tick();
    drive(7, 0, 0, 7, 1, 1, 1);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b110) begin
      errors++;
      $display("FAIL flush_nostall got=%b exp=110",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    tick();
    // A stall right after the flushed cycle proves the FSM stayed in RUN.
    drive(7, 0, 0, 7, 1, 1, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b001) begin
      errors++;
      $display("FAIL flush_state_run got=%b exp=001",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("test_zero_and_flush done");
  endtask

  task automatic test_protocol_error();
    drive(5, 0, 0, 5, 1, 1, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b001) begin
      errors++;
      $display("FAIL perr_first_stall got=%b exp=001",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    tick();
    drive(5, 0, 0, 5, 1, 1, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble, bus.Protocol_Error} !== 4'b1100) begin
      errors++;
      $display("FAIL perr_second_cycle got=%b exp=1100",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble, bus.Protocol_Error});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.Protocol_Error !== 1'b1) begin
        errors++;
        $display("FAIL perr_sticky[%0d] got=%b exp=1", i, bus.Protocol_Error);
      end
      tick();
    end
    $display("test_protocol_error done");
  endtask

  task automatic test_reset_mid_stall();
    drive(5, 0, 0, 5, 1, 1, 0);
    checks++;
    if (bus.ID_EX_Bubble !== 1'b1) begin
      errors++;
      $display("FAIL rms_enter_stall got=%b exp=1", bus.ID_EX_Bubble);
    end
    tick();
    rst_n = 1'b0;
    drive(5, 0, 0, 5, 1, 1, 0);
    checks++;
    if ({bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble} !== 3'b110) begin
      errors++;
      $display("FAIL rms_forced got=%b exp=110",
               {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Bubble});
    end
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_out() !== RESET_OUT) begin
      errors++;
      $display("FAIL rms_reset_state got=%h exp=%h", dut_out(), RESET_OUT);
    end
    drive(4, 0, 0, 4, 1, 1, 0);
    checks++;
    if (bus.ID_EX_Bubble !== 1'b1) begin
      errors++;
      $display("FAIL rms_run_after_reset got=%b exp=1", bus.ID_EX_Bubble);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("test_reset_mid_stall done");
  endtask

  task automatic test_random(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 7) == 0));
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        bad++;
        $display("FAIL random[%0d] got=%h exp=%h", i, dut_out(), model_out());
      end
      tick();
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("test_random done: %0d cycles, %0d bad", n, bad);
  endtask

  task automatic test_saturate();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      drive(6, 0, 0, 6, 1, 1, 0);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL sat_step[%0d] got=%h exp=%h", i, dut_out(), model_out());
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    checks++;
    if (bus.Stall_Count !== CW'(CNT_MAX)) begin
      errors++;
      $display("FAIL sat_hold got=%0d exp=%0d", bus.Stall_Count, CNT_MAX);
    end
    $display("test_saturate done");
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    test_reset();
    test_forward_add();
    test_load_use_rs();
    test_rt_uses();
    test_zero_and_flush();
    test_protocol_error();
    test_reset_mid_stall();
    test_random(400);
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
